hazard_unit_md: RTL and testbench

HAZARD_UNIT_MD -- requirements
Module: hazard_unit_md

---
 rtl/hazard_unit_md.sv | 105 ++++++++++
 tb/tb_hazard_unit_md.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_md.sv
// Hazard detection for a 5-stage MIPS-style pipeline. It decides stalls and
// forward selects, and tracks how long the multi-cycle HI/LO unit stays busy.
module hazard_unit_md #(
  parameter int RA_W    = 5,
  parameter int T_W     = 4,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  ID_Rs,
  input  logic [RA_W-1:0]  ID_Rt,
  input  logic [T_W-1:0]   ID_Tuse_rs,
  input  logic [T_W-1:0]   ID_Tuse_rt,
  input  logic             ID_is_md,
  input  logic [RA_W-1:0]  EX_Rs,
  input  logic [RA_W-1:0]  EX_Rt,
  input  logic [RA_W-1:0]  EX_WA,
  input  logic [RA_W-1:0]  MEM_WA,
  input  logic [RA_W-1:0]  WB_WA,
  input  logic             EX_RegWrite,
  input  logic             MEM_RegWrite,
  input  logic             WB_RegWrite,
  input  logic [T_W-1:0]   EX_Tnew,
  input  logic [T_W-1:0]   MEM_Tnew,
  input  logic             EX_md_start,
  input  logic             EX_md_is_div,
  output logic             npc_stall,
  output logic             IF_stall,
  output logic             ID_clr,
  output logic [1:0]       FowardAD,
  output logic [1:0]       FowardBD,
  output logic [1:0]       FowardAE,
  output logic [1:0]       FowardBE,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int MD_W    = $clog2(MAX_LAT + 1);
  localparam logic [MD_W-1:0] MUL_LD = MD_W'(MUL_LAT);
  localparam logic [MD_W-1:0] DIV_LD = MD_W'(DIV_LAT);

  function automatic logic hit(input logic rw, input logic [RA_W-1:0] wa,
                               input logic [RA_W-1:0] src);
    return rw && (wa == src) && (wa != '0);
  endfunction

  // MEM only forwards once its result exists; otherwise WB gets its turn.
  function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic mem_ready,
                                         input logic wb_hit);
    if (mem_hit && mem_ready) return 2'b10;
    else if (wb_hit)          return 2'b01;
    else                      return 2'b00;
  endfunction

  function automatic logic data_stall(input logic ex_hit, input logic mem_hit,
                                      input logic [T_W-1:0] ex_tnew,
                                      input logic [T_W-1:0] mem_tnew,
                                      input logic [T_W-1:0] tuse);
    return (ex_hit && (ex_tnew > tuse)) || (mem_hit && (mem_tnew > tuse));
  endfunction

  logic            mem_ready;
  logic            stall_rs;
  logic            stall_rt;
  logic            md_stall;
  logic [MD_W-1:0] md_cnt;

  assign mem_ready = (MEM_Tnew == '0);

  assign stall_rs = data_stall(hit(EX_RegWrite, EX_WA, ID_Rs), hit(MEM_RegWrite, MEM_WA, ID_Rs),
                               EX_Tnew, MEM_Tnew, ID_Tuse_rs);
  assign stall_rt = data_stall(hit(EX_RegWrite, EX_WA, ID_Rt), hit(MEM_RegWrite, MEM_WA, ID_Rt),
                               EX_Tnew, MEM_Tnew, ID_Tuse_rt);

  assign md_busy   = EX_md_start || (md_cnt != '0);
  assign md_stall  = ID_is_md && md_busy;
  assign npc_stall = stall_rs || stall_rt || md_stall;
  assign IF_stall  = npc_stall;
  assign ID_clr    = npc_stall;

  assign FowardAD = fwd_sel(hit(MEM_RegWrite, MEM_WA, ID_Rs), mem_ready,
                            hit(WB_RegWrite, WB_WA, ID_Rs));
  assign FowardBD = fwd_sel(hit(MEM_RegWrite, MEM_WA, ID_Rt), mem_ready,
                            hit(WB_RegWrite, WB_WA, ID_Rt));
  assign FowardAE = fwd_sel(hit(MEM_RegWrite, MEM_WA, EX_Rs), mem_ready,
                            hit(WB_RegWrite, WB_WA, EX_Rs));
  assign FowardBE = fwd_sel(hit(MEM_RegWrite, MEM_WA, EX_Rt), mem_ready,
                            hit(WB_RegWrite, WB_WA, EX_Rt));

  // A new issue always reloads, discarding whatever count was in flight.
  always_ff @(posedge clk) begin
    if (reset)            md_cnt <= '0;
    else if (EX_md_start) md_cnt <= EX_md_is_div ? DIV_LD : MUL_LD;
    else if (md_cnt != '0) md_cnt <= md_cnt - MD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)                           stall_cnt <= '0;
    else if (npc_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_unit_md.sv
// Directed bench for hazard_unit_md: stalls, forwarding priority, HI/LO busy
// timing, reset and counter saturation (second instance with a 4-bit counter).
module tb_hazard_unit_md;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_WA, MEM_WA, WB_WA;
  logic [3:0] ID_Tuse_rs, ID_Tuse_rt, EX_Tnew, MEM_Tnew;
  logic       ID_is_md, EX_RegWrite, MEM_RegWrite, WB_RegWrite, EX_md_start, EX_md_is_div;

  logic        npc_stall, IF_stall, ID_clr, md_busy;
  logic [1:0]  FowardAD, FowardBD, FowardAE, FowardBE;
  logic [31:0] stall_cnt;

  logic        s_npc_stall, s_IF_stall, s_ID_clr, s_md_busy;
  logic [1:0]  s_FowardAD, s_FowardBD, s_FowardAE, s_FowardBE;
  logic [3:0]  s_stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_unit_md dut (
    .clk(clk), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_Tuse_rs(ID_Tuse_rs), .ID_Tuse_rt(ID_Tuse_rt), .ID_is_md(ID_is_md),
    .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_WA(EX_WA), .MEM_WA(MEM_WA), .WB_WA(WB_WA),
    .EX_RegWrite(EX_RegWrite), .MEM_RegWrite(MEM_RegWrite), .WB_RegWrite(WB_RegWrite),
    .EX_Tnew(EX_Tnew), .MEM_Tnew(MEM_Tnew), .EX_md_start(EX_md_start),
    .EX_md_is_div(EX_md_is_div), .npc_stall(npc_stall), .IF_stall(IF_stall),
    .ID_clr(ID_clr), .FowardAD(FowardAD), .FowardBD(FowardBD), .FowardAE(FowardAE),
    .FowardBE(FowardBE), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  hazard_unit_md #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_Tuse_rs(ID_Tuse_rs), .ID_Tuse_rt(ID_Tuse_rt), .ID_is_md(ID_is_md),
    .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_WA(EX_WA), .MEM_WA(MEM_WA), .WB_WA(WB_WA),
    .EX_RegWrite(EX_RegWrite), .MEM_RegWrite(MEM_RegWrite), .WB_RegWrite(WB_RegWrite),
    .EX_Tnew(EX_Tnew), .MEM_Tnew(MEM_Tnew), .EX_md_start(EX_md_start),
    .EX_md_is_div(EX_md_is_div), .npc_stall(s_npc_stall), .IF_stall(s_IF_stall),
    .ID_clr(s_ID_clr), .FowardAD(s_FowardAD), .FowardBD(s_FowardBD), .FowardAE(s_FowardAE),
    .FowardBE(s_FowardBE), .md_busy(s_md_busy), .stall_cnt(s_stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ID_Rs = '0; ID_Rt = '0; EX_Rs = '0; EX_Rt = '0;
    EX_WA = '0; MEM_WA = '0; WB_WA = '0;
    ID_Tuse_rs = '0; ID_Tuse_rt = '0; EX_Tnew = '0; MEM_Tnew = '0;
    ID_is_md = 1'b0; EX_RegWrite = 1'b0; MEM_RegWrite = 1'b0; WB_RegWrite = 1'b0;
    EX_md_start = 1'b0; EX_md_is_div = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_md_busy", md_busy, 0);
    chk("rst_npc_stall", npc_stall, 0);
    chk("rst_fwd_ad", FowardAD, 2'b00);

    // Combinational cases: inputs set and checked within one cycle.
    EX_RegWrite = 1; EX_WA = 8; EX_Tnew = 2; ID_Rs = 8; ID_Tuse_rs = 0;
    #1;
    chk("lu_npc_stall", npc_stall, 1);
    chk("lu_if_stall", IF_stall, 1);
    chk("lu_id_clr", ID_clr, 1);
    EX_Tnew = 0; MEM_RegWrite = 1; MEM_WA = 8; MEM_Tnew = 0;
    #1;
    chk("lu_fwd_ad_mem", FowardAD, 2'b10);
    chk("lu_no_stall", npc_stall, 0);
    MEM_Tnew = 1;
    #1;
    chk("mem_tnew_stall", npc_stall, 1);
    chk("mem_tnew_no_fwd", FowardAD, 2'b00);
    ID_Tuse_rs = 1;
    #1;
    chk("mem_tuse_ok", npc_stall, 0);
    clear_inputs();
    EX_RegWrite = 1; EX_WA = 3; EX_Tnew = 1; ID_Rt = 3; ID_Tuse_rt = 0;
    #1;
    chk("rt_stall", npc_stall, 1);
    EX_WA = 0; ID_Rt = 0;
    #1;
    chk("r0_no_stall", npc_stall, 0);
    clear_inputs();
    MEM_RegWrite = 1; WB_RegWrite = 1; MEM_WA = 9; WB_WA = 9; MEM_Tnew = 0;
    EX_Rt = 9; EX_Rs = 9; ID_Rt = 9;
    #1;
    chk("prio_be_mem", FowardBE, 2'b10);
    chk("prio_ae_mem", FowardAE, 2'b10);
    chk("prio_bd_mem", FowardBD, 2'b10);
    chk("sat_fwd_be", s_FowardBE, 2'b10);
    chk("sat_fwd_ae", s_FowardAE, 2'b10);
    chk("sat_fwd_bd", s_FowardBD, 2'b10);
    chk("sat_fwd_ad", s_FowardAD, 2'b00);
    MEM_Tnew = 1;
    #1;
    chk("prio_be_wb", FowardBE, 2'b01);
    MEM_WA = 0; WB_WA = 0;
    #1;
    chk("prio_be_zero", FowardBE, 2'b00);
    clear_inputs();
    tick();
    chk("no_stall_counted", stall_cnt, 0);

    // Divide: busy for the start cycle plus DIV_LAT cycles.
    ID_is_md = 1; EX_md_start = 1; EX_md_is_div = 1;
    #1;
    chk("div_busy_start", md_busy, 1);
    chk("div_stall_start", npc_stall, 1);
    tick();
    EX_md_start = 0;
    for (int i = 1; i <= 10; i++) begin
      chk($sformatf("div_busy_%0d", i), md_busy, 1);
      chk($sformatf("div_stall_%0d", i), npc_stall, 1);
      tick();
    end
    chk("div_busy_end", md_busy, 0);
    chk("div_stall_end", npc_stall, 0);
    chk("div_stall_cnt", stall_cnt, 11);
    chk("sat_div_stall_cnt", s_stall_cnt, 11);

    // Restart: mult, then div two cycles later reloads to DIV_LAT.
    clear_inputs();
    EX_md_start = 1; EX_md_is_div = 0;
    tick();
    EX_md_start = 0;
    tick();
    EX_md_start = 1; EX_md_is_div = 1;
    #1;
    chk("rs_busy_start", md_busy, 1);
    tick();
    EX_md_start = 0;
    for (int i = 1; i <= 10; i++) begin
      chk($sformatf("rs_busy_%0d", i), md_busy, 1);
      tick();
    end
    chk("rs_busy_end", md_busy, 0);

    // Reset four cycles into a divide.
    do_reset();
    ID_is_md = 1; EX_md_start = 1; EX_md_is_div = 1;
    tick();
    EX_md_start = 0;
    tick();
    tick();
    tick();
    chk("mid_div_busy", md_busy, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("rst_div_busy", md_busy, 0);
    chk("rst_div_stall", npc_stall, 0);
    chk("rst_div_cnt", stall_cnt, 0);
    chk("rst_div_sat_cnt", s_stall_cnt, 0);

    // Saturation: 20 stall cycles into a 4-bit counter.
    EX_md_start = 1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_busy", s_md_busy, 1);
    chk("sat_npc", s_npc_stall, 1);
    chk("sat_if", s_IF_stall, 1);
    chk("sat_clr", s_ID_clr, 1);
    chk("sat_cnt4", s_stall_cnt, 4'hF);
    chk("sat_cnt32", stall_cnt, 20);
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
